// File: rtl/csu_pkg.sv
// Shared definitions for the context switch unit.
//   csu_cmd_e   : kernel command opcodes on cmd_op
//   csu_cause_e : trap cause reported on trap_cause
//   csu_state_e : controller state (kernel or user process)
package csu_pkg;

  typedef enum logic [1:0] {
    CMD_SET_PC      = 2'd0,
    CMD_KILL        = 2'd1,
    CMD_SET_QUANTUM = 2'd2,
    CMD_LAUNCH      = 2'd3
  } csu_cmd_e;

  typedef enum logic {
    CAUSE_SYSCALL = 1'b0,
    CAUSE_EXPIRY  = 1'b1
  } csu_cause_e;

  typedef enum logic {
    KERNEL = 1'b0,
    PROG   = 1'b1
  } csu_state_e;

endpackage

// File: rtl/csu_rr_pick.sv
// Combinational round-robin slot picker.
//   active_i   : slot-valid mask
//   cur_proc_i : slot the search starts after
//   next_o     : first active slot strictly after cur_proc_i, wrapping;
//                equals cur_proc_i when it is the only active slot
//   found_o    : at least one slot is active
module csu_rr_pick #(
  parameter int NUM_PROCS = 4
) (
  input  logic [NUM_PROCS-1:0]         active_i,
  input  logic [$clog2(NUM_PROCS)-1:0] cur_proc_i,
  output logic [$clog2(NUM_PROCS)-1:0] next_o,
  output logic                         found_o
);

  localparam int IW = $clog2(NUM_PROCS);

  // Scan from the farthest offset down to the nearest so the nearest
  // active slot is the last (winning) assignment. Offset NUM_PROCS wraps
  // to cur_proc_i itself because NUM_PROCS is a power of two.
  always_comb begin
    logic [IW-1:0] idx;
    idx     = '0;
    next_o  = cur_proc_i;
    found_o = 1'b0;
    for (int i = NUM_PROCS; i >= 1; i--) begin
      idx = cur_proc_i + IW'(i);
      if (active_i[idx]) begin
        next_o  = idx;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/context_switch_unit.sv
// Program/kernel mode controller with a per-process saved-PC table,
// round-robin dispatch and an optional preemption quantum timer.
//
// Build option: CSU_PREEMPT_EN -- when defined, a quantum counter is built
// and a process traps after its quantum of retired steps; otherwise a
// process leaves PROG only on syscall and SET_QUANTUM is a silent no-op.
//
// Ports:
//   clock, reset      : clock, asynchronous active-low reset
//   step, syscall     : instruction retire strobe and syscall decode
//   pc_prox           : PC of the next instruction, saved on trap
//   cmd_valid/op/proc/data : kernel command port
//   prog_or_kernel    : 1 = user process running
//   pc_load/pc_target : one-cycle PC load request and its value
//   cur_proc          : running or last-run slot
//   active            : slot-valid mask
//   trap_cause        : cause of the most recent trap
//   cmd_error         : one-cycle pulse on a rejected command
module context_switch_unit
  import csu_pkg::*;
#(
  parameter int NUM_PROCS       = 4,
  parameter int PC_WIDTH        = 32,
  parameter int QUANTUM_WIDTH   = 16,
  parameter int DEFAULT_QUANTUM = 100,
  parameter int KERNEL_ENTRY    = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         step,
  input  logic                         syscall,
  input  logic [PC_WIDTH-1:0]          pc_prox,
  input  logic                         cmd_valid,
  input  logic [1:0]                   cmd_op,
  input  logic [$clog2(NUM_PROCS)-1:0] cmd_proc,
  input  logic [PC_WIDTH-1:0]          cmd_data,
  output logic                         prog_or_kernel,
  output logic                         pc_load,
  output logic [PC_WIDTH-1:0]          pc_target,
  output logic [$clog2(NUM_PROCS)-1:0] cur_proc,
  output logic [NUM_PROCS-1:0]         active,
  output logic                         trap_cause,
  output logic                         cmd_error
);

  localparam int IW = $clog2(NUM_PROCS);
  localparam int QW = QUANTUM_WIDTH;

  csu_state_e           state_q, state_d;
  logic                 pc_load_q, pc_load_d;
  logic [PC_WIDTH-1:0]  pc_target_q, pc_target_d;
  logic [IW-1:0]        cur_proc_q, cur_proc_d;
  logic [NUM_PROCS-1:0] active_q, active_d;
  logic                 trap_cause_q, trap_cause_d;
  logic                 cmd_error_q, cmd_error_d;

  // Register array (not RAM): LAUNCH reads an entry combinationally.
  logic [PC_WIDTH-1:0]  pc_table_q [NUM_PROCS];
  logic                 tbl_we;
  logic [IW-1:0]        tbl_idx;
  logic [PC_WIDTH-1:0]  tbl_wdata;

  logic [IW-1:0]        pick_next;
  logic                 pick_found;
  logic                 do_trap;
  csu_cause_e           cause;

`ifdef CSU_PREEMPT_EN
  logic [QW-1:0]        quantum_q, quantum_d;
  logic [QW-1:0]        count_q, count_d;

  // A zero quantum would never expire; treat it as one step.
  function automatic logic [QW-1:0] floor_quantum(input logic [QW-1:0] q);
    return (q == '0) ? QW'(1) : q;
  endfunction
`else
  // Quantum parameters have no hardware in this build.
  logic [QW-1:0]        unused_quantum;
  assign unused_quantum = QW'(DEFAULT_QUANTUM);
`endif

  csu_rr_pick #(
    .NUM_PROCS (NUM_PROCS)
  ) u_pick (
    .active_i   (active_q),
    .cur_proc_i (cur_proc_q),
    .next_o     (pick_next),
    .found_o    (pick_found)
  );

  always_comb begin
    state_d      = state_q;
    pc_load_d    = 1'b0;
    pc_target_d  = pc_target_q;
    cur_proc_d   = cur_proc_q;
    active_d     = active_q;
    trap_cause_d = trap_cause_q;
    cmd_error_d  = 1'b0;
    tbl_we       = 1'b0;
    tbl_idx      = cur_proc_q;
    tbl_wdata    = pc_prox;
    do_trap      = 1'b0;
    cause        = CAUSE_SYSCALL;
`ifdef CSU_PREEMPT_EN
    quantum_d    = quantum_q;
    count_d      = count_q;
`endif

    case (state_q)
      KERNEL: begin
        if (cmd_valid) begin
          case (csu_cmd_e'(cmd_op))
            CMD_SET_PC: begin
              tbl_we             = 1'b1;
              tbl_idx            = cmd_proc;
              tbl_wdata          = cmd_data;
              active_d[cmd_proc] = 1'b1;
            end
            CMD_KILL: begin
              active_d[cmd_proc] = 1'b0;
            end
            CMD_SET_QUANTUM: begin
`ifdef CSU_PREEMPT_EN
              quantum_d = floor_quantum(cmd_data[QW-1:0]);
`endif
            end
            CMD_LAUNCH: begin
              if (pick_found) begin
                cur_proc_d  = pick_next;
                pc_target_d = pc_table_q[pick_next];
                pc_load_d   = 1'b1;
                state_d     = PROG;
`ifdef CSU_PREEMPT_EN
                count_d     = quantum_q;
`endif
              end else begin
                cmd_error_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      PROG: begin
        if (cmd_valid) begin
          cmd_error_d = 1'b1;
        end
        if (step) begin
          if (syscall) begin
            do_trap = 1'b1;
            cause   = CAUSE_SYSCALL;
          end
`ifdef CSU_PREEMPT_EN
          else if (count_q == QW'(1)) begin
            do_trap = 1'b1;
            cause   = CAUSE_EXPIRY;
          end else begin
            count_d = count_q - QW'(1);
          end
`endif
        end
        if (do_trap) begin
          tbl_we       = 1'b1;
          tbl_idx      = cur_proc_q;
          tbl_wdata    = pc_prox;
          pc_target_d  = PC_WIDTH'(KERNEL_ENTRY);
          pc_load_d    = 1'b1;
          trap_cause_d = cause;
          state_d      = KERNEL;
        end
      end

      default: state_d = KERNEL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= KERNEL;
      pc_load_q    <= 1'b0;
      pc_target_q  <= '0;
      cur_proc_q   <= IW'(NUM_PROCS - 1);
      active_q     <= '0;
      trap_cause_q <= 1'b0;
      cmd_error_q  <= 1'b0;
`ifdef CSU_PREEMPT_EN
      quantum_q    <= QW'(DEFAULT_QUANTUM);
      count_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pc_load_q    <= pc_load_d;
      pc_target_q  <= pc_target_d;
      cur_proc_q   <= cur_proc_d;
      active_q     <= active_d;
      trap_cause_q <= trap_cause_d;
      cmd_error_q  <= cmd_error_d;
`ifdef CSU_PREEMPT_EN
      quantum_q    <= quantum_d;
      count_q      <= count_d;
`endif
    end
  end

  // Saved PCs are data only; their reset contents are irrelevant because
  // a slot cannot be launched before SET_PC marks it active.
  always_ff @(posedge clock) begin
    if (tbl_we) begin
      pc_table_q[tbl_idx] <= tbl_wdata;
    end
  end

  assign prog_or_kernel = (state_q == PROG);
  assign pc_load        = pc_load_q;
  assign pc_target      = pc_target_q;
  assign cur_proc       = cur_proc_q;
  assign active         = active_q;
  assign trap_cause     = trap_cause_q;
  assign cmd_error      = cmd_error_q;

endmodule
